// File: rtl/fetch_sequencer.sv
// Fetch sequencer: owns the PC and issues one imem request at a time; REQ->WAIT->HOLD gives >=3 cycles/instr.
// Stalls in REQ until imem_req_ready and in HOLD until if_ready; memory responses are never stalled.
module fetch_sequencer #(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter logic [XLEN-1:0] HALT_PC  = 'h13c
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic            if_valid,
  output logic [XLEN-1:0] if_pc,
  output logic [31:0]     if_instr,
  input  logic            if_ready,
  output logic            halted,
  output logic [31:0]     fetch_count
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    HOLD = 3'd3,
    HALT = 3'd4
  } state_t;

  localparam logic [XLEN-1:0] PC_STEP   = 'd4;
  localparam logic [31:0]     COUNT_MAX = 32'hFFFF_FFFF;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            drop_q, drop_d;
  logic [XLEN-1:0] if_pc_q, if_pc_d;
  logic [31:0]     if_instr_q, if_instr_d;
  logic [31:0]     count_q, count_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      drop_q     <= 1'b0;
      if_pc_q    <= '0;
      if_instr_q <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      drop_q     <= drop_d;
      if_pc_q    <= if_pc_d;
      if_instr_q <= if_instr_d;
      count_q    <= count_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    drop_d     = drop_q;
    if_pc_d    = if_pc_q;
    if_instr_d = if_instr_q;
    count_d    = count_q;

    case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        if (imem_req_ready) state_d = WAIT;
      end
      WAIT: begin
        if (imem_rsp_valid) begin
          if (drop_q) begin
            drop_d  = 1'b0;
            state_d = REQ;
          end else begin
            if_pc_d    = pc_q;
            if_instr_d = imem_rsp_data;
            state_d    = HOLD;
          end
        end
      end
      HOLD: begin
        if (if_ready) begin
          if (count_q != COUNT_MAX) count_d = count_q + 32'd1;
          pc_d    = pc_q + PC_STEP;
          state_d = (if_pc_q == HALT_PC) ? HALT : REQ;
        end
      end
      HALT: state_d = HALT;
      default: state_d = IDLE;
    endcase

    // A redirect wins over everything above: undo any capture/count and
    // decide only whether an in-flight response must be swallowed.
    if (redirect_valid) begin
      pc_d       = redirect_pc;
      if_pc_d    = if_pc_q;
      if_instr_d = if_instr_q;
      count_d    = count_q;
      case (state_q)
        REQ: begin
          if (imem_req_ready) begin
            state_d = WAIT;
            drop_d  = 1'b1;
          end else begin
            state_d = REQ;
          end
        end
        WAIT: begin
          if (imem_rsp_valid) begin
            state_d = REQ;
            drop_d  = 1'b0;
          end else begin
            state_d = WAIT;
            drop_d  = 1'b1;
          end
        end
        default: begin
          state_d = REQ;
          drop_d  = 1'b0;
        end
      endcase
    end
  end

  assign imem_req_valid = (state_q == REQ);
  assign imem_req_addr  = pc_q;
  assign if_valid       = (state_q == HOLD);
  assign if_pc          = if_pc_q;
  assign if_instr       = if_instr_q;
  assign halted         = (state_q == HALT);
  assign fetch_count    = count_q;

endmodule
